color_xform_arbiter: RTL

- Round-robin scheduler that shares one COLOR_TRANSFORM pipeline between two pixel requesters, for example two capture streams.
- Issues at most one pixel per clk_25 cycle onto the transform inputs.
- Throttles issue against the occupancy of the downstream write FIFO, using an in-flight credit count. The transform itself cannot stall.
- Emits a source tag that is time-aligned with the transform's wrreq output, so the FIFO can store the originating stream.

---
 rtl/color_xform_arbiter_pkg.sv | 25 ++
 rtl/color_xform_arbiter_tag_pipe.sv | 42 ++++
 rtl/color_xform_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/color_xform_arbiter_pkg.sv
// Shared types for the colour-transform arbiter:
// pixel bundle, FSM encoding and requester ids.
package color_xform_arbiter_pkg;

  localparam int COORD_W = 10;
  localparam int CH_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [CH_W-1:0]    r;
    logic [CH_W-1:0]    g;
    logic [CH_W-1:0]    b;
  } pixel_t;

endpackage

// File: rtl/color_xform_arbiter_tag_pipe.sv
// Delay line carrying {valid, src} alongside the transform
// so the source id leaves in step with its wrreq.
module xform_tag_pipe #(
  parameter int PIPE_LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_in,
  input  logic src_in,
  input  logic wr_req,
  output logic vld_out,
  output logic src_out
);

  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [PIPE_LAT-1:0] src_q, src_d;

  always_comb begin
    vld_d = (vld_q << 1) | PIPE_LAT'(vld_in);
    src_d = (src_q << 1) | PIPE_LAT'(src_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      src_q <= '0;
    end else begin
      vld_q <= vld_d;
      src_q <= src_d;
    end
  end

  assign vld_out = vld_q[PIPE_LAT-1];
  assign src_out = src_q[PIPE_LAT-1];

  // A tagged pixel must retire exactly when its tag pops out.
  a_align : assert property (
    @(posedge clk) disable iff (!rst_n)
    vld_out |-> wr_req
  );

endmodule

// File: rtl/color_xform_arbiter.sv
// Round-robin issue of two pixel streams into one
// colour transform, throttled by FIFO credit.
module color_xform_arbiter
  import color_xform_arbiter_pkg::*;
#(
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 512,
  parameter int USEDW_W    = 9,
  parameter int MARGIN     = 2,
  parameter int CNT_W      = 3
) (
  input  logic               clk_25,
  input  logic               reset,
  input  logic               en,
  input  logic               req0,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [3*CH_W-1:0]  rgb0,
  output logic               ack0,
  input  logic               req1,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [3*CH_W-1:0]  rgb1,
  output logic               ack1,
  output logic               tr_valid,
  output logic [COORD_W-1:0] tr_x,
  output logic [COORD_W-1:0] tr_y,
  output logic [CH_W-1:0]    tr_red,
  output logic [CH_W-1:0]    tr_green,
  output logic [CH_W-1:0]    tr_blue,
  input  logic               tr_wrreq,
  input  logic [USEDW_W-1:0] wrusedw,
  output logic               wr_src,
  output logic               busy
);

  localparam logic [USEDW_W:0] LIMIT =
    (USEDW_W+1)'(FIFO_DEPTH - MARGIN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             last_q, last_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             vld_q, vld_d;
  logic             src_q, src_d;
  pixel_t           pix_q, pix_d;

  logic             elig0, elig1;
  logic             credit_ok;
  logic             grant, gnt_id;
  logic             retire;
  logic [USEDW_W:0] occ;
  logic             tag_vld, tag_src;
  pixel_t           pix0, pix1;

  assign pix0 = pixel_t'({x0, y0, rgb0});
  assign pix1 = pixel_t'({x1, y1, rgb1});

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en) begin
          state_d = ST_RUN;
        end else if (inflight_q == '0 && !vld_q) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // A pending ack blocks re-sampling the same pixel.
  always_comb begin
    elig0     = req0 & ~ack0_q;
    elig1     = req1 & ~ack1_q;
    occ       = {1'b0, wrusedw}
              + (USEDW_W+1)'(inflight_q);
    credit_ok = (occ < LIMIT);
    grant     = 1'b0;
    gnt_id    = REQ_0;
    if (state_q == ST_RUN && en && credit_ok) begin
      unique case (1'b1)
        (elig0 & elig1): begin
          grant  = 1'b1;
          gnt_id = ~last_q;
        end
        (elig0 & ~elig1): begin
          grant  = 1'b1;
          gnt_id = REQ_0;
        end
        (~elig0 & elig1): begin
          grant  = 1'b1;
          gnt_id = REQ_1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack0_d = grant && (gnt_id == REQ_0);
    ack1_d = grant && (gnt_id == REQ_1);
    vld_d  = grant;
    src_d  = grant ? gnt_id : src_q;
    last_d = grant ? gnt_id : last_q;
    pix_d  = pix_q;
    if (grant) begin
      pix_d = (gnt_id == REQ_1) ? pix1 : pix0;
    end
    retire     = tr_wrreq && (inflight_q != '0);
    inflight_d = inflight_q;
    unique case ({grant, retire})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
      last_q     <= REQ_1;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      vld_q      <= 1'b0;
      src_q      <= 1'b0;
      pix_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      last_q     <= last_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      vld_q      <= vld_d;
      src_q      <= src_d;
      pix_q      <= pix_d;
    end
  end

  xform_tag_pipe #(
    .PIPE_LAT (PIPE_LAT)
  ) u_tag (
    .clk     (clk_25),
    .rst_n   (reset),
    .vld_in  (vld_q),
    .src_in  (src_q),
    .wr_req  (tr_wrreq),
    .vld_out (tag_vld),
    .src_out (tag_src)
  );

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign tr_valid = vld_q;
  assign tr_x     = pix_q.x;
  assign tr_y     = pix_q.y;
  assign tr_red   = pix_q.r;
  assign tr_green = pix_q.g;
  assign tr_blue  = pix_q.b;
  assign wr_src   = tag_vld & tag_src;

endmodule
